gemm_result_streamer: RTL and testbench

//  Downstream of gemm_top. On gemm_top's done edge it snapshots the full result matrix.
//  It then streams the elements out one per handshake, row-major, over a valid/ready interface.

---
 rtl/gemm_result_streamer.sv | 162 ++++++++++++++++
 tb/tb_gemm_result_streamer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_result_streamer.sv
// Snapshots the GEMM result matrix on the rising edge of idone and streams it row-major over valid/ready.
// Optional trailing XOR checksum beat is enabled by defining GEMM_STREAM_CHECKSUM_EN.
module gemm_result_streamer #(
  parameter int DATA_WIDTH    = 64,
  parameter int MATRIX_HEIGHT = 4,
  parameter int MATRIX_WIDTH  = 4,
  localparam int RW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1,
  localparam int CW = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  idone,
  input  logic [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1][DATA_WIDTH-1:0] iresult_matrix,
  input  logic                  iready,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  ovalid,
  output logic                  olast,
  output logic [RW-1:0]         orow,
  output logic [CW-1:0]         ocol,
  output logic                  ochk,
  output logic                  obusy,
  output logic                  ostream_done,
  output logic                  ooverrun
);

`ifdef GEMM_STREAM_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_STREAM} state_t;
`endif

  typedef logic [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1][DATA_WIDTH-1:0] mat_t;

  state_t          state_q, state_d;
  mat_t            buf_q, buf_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            done_q;
  logic            stream_done_q, stream_done_d;
  logic            overrun_q, overrun_d;
  logic            capture;
  logic            elem_last;
`ifdef GEMM_STREAM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_q, chk_d;
`endif

  assign capture   = idone & ~done_q;
  assign elem_last = (row_q == RW'(MATRIX_HEIGHT - 1)) && (col_q == CW'(MATRIX_WIDTH - 1));

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    row_d         = row_q;
    col_d         = col_q;
    stream_done_d = 1'b0;
    overrun_d     = overrun_q;
`ifdef GEMM_STREAM_CHECKSUM_EN
    chk_d         = chk_q;
`endif
    odata  = '0;
    ovalid = 1'b0;
    olast  = 1'b0;
    orow   = '0;
    ocol   = '0;
    ochk   = 1'b0;
    obusy  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          buf_d   = iresult_matrix;
          row_d   = '0;
          col_d   = '0;
`ifdef GEMM_STREAM_CHECKSUM_EN
          chk_d   = '0;
`endif
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        ovalid = 1'b1;
        obusy  = 1'b1;
        odata  = buf_q[row_q][col_q];
        orow   = row_q;
        ocol   = col_q;
`ifndef GEMM_STREAM_CHECKSUM_EN
        olast  = elem_last;
`endif
        // A new capture here (including on the final handshake) is dropped, never restarted.
        if (capture) overrun_d = 1'b1;
        if (iready) begin
`ifdef GEMM_STREAM_CHECKSUM_EN
          chk_d = chk_q ^ buf_q[row_q][col_q];
`endif
          if (elem_last) begin
            row_d = '0;
            col_d = '0;
`ifdef GEMM_STREAM_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d       = S_IDLE;
            stream_done_d = 1'b1;
`endif
          end else if (col_q == CW'(MATRIX_WIDTH - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
`ifdef GEMM_STREAM_CHECKSUM_EN
      S_CHK: begin
        ovalid = 1'b1;
        obusy  = 1'b1;
        odata  = chk_q;
        ochk   = 1'b1;
        olast  = 1'b1;
        if (capture) overrun_d = 1'b1;
        if (iready) begin
          state_d       = S_IDLE;
          stream_done_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign ostream_done = stream_done_q;
  assign ooverrun     = overrun_q;

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      done_q        <= 1'b1;
      stream_done_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef GEMM_STREAM_CHECKSUM_EN
      chk_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      done_q        <= idone;
      stream_done_q <= stream_done_d;
      overrun_q     <= overrun_d;
`ifdef GEMM_STREAM_CHECKSUM_EN
      chk_q         <= chk_d;
`endif
    end
  end

  // Snapshot storage needs no reset: it is only observed while a frame is active.
  always_ff @(posedge iclk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_gemm_result_streamer.sv
// Scoreboard bench for gemm_result_streamer: directed frames push expected beats, a monitor pops on handshake.
module tb_gemm_result_streamer;
  localparam int DW = 64;
  localparam int H  = 4;
  localparam int W  = 4;

  typedef logic [0:H-1][0:W-1][DW-1:0] mat_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          last;
    logic          chk;
  } beat_t;

  logic          iclk = 1'b0;
  logic          irst, idone, iready;
  mat_t          mat;
  logic [DW-1:0] odata;
  logic          ovalid, olast, ochk, obusy, ostream_done, ooverrun;
  logic [1:0]    orow, ocol;

  gemm_result_streamer #(.DATA_WIDTH(DW), .MATRIX_HEIGHT(H), .MATRIX_WIDTH(W)) dut (
    .iclk(iclk), .irst(irst), .idone(idone), .iresult_matrix(mat), .iready(iready),
    .odata(odata), .ovalid(ovalid), .olast(olast), .orow(orow), .ocol(ocol), .ochk(ochk),
    .obusy(obusy), .ostream_done(ostream_done), .ooverrun(ooverrun)
  );

  always #5 iclk = ~iclk;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    hs_count = 0;
  logic  last_hs_prev = 1'b0;

`ifdef GEMM_STREAM_CHECKSUM_EN
  localparam int BEATS = H * W + 1;
`else
  localparam int BEATS = H * W;
`endif

  // Monitor: a beat is accepted at the next posedge when ovalid & iready are seen here.
  always @(negedge iclk) begin
    beat_t e;
    if (ostream_done === 1'b1 || last_hs_prev) begin
      n_cmp++;
      if (ostream_done !== last_hs_prev) begin
        n_bad++;
        $display("FAIL stream_done_pulse got=%0b want=%0b t=%0t", ostream_done, last_hs_prev, $time);
      end
    end
    last_hs_prev = 1'b0;
    if (ovalid === 1'b1 && iready === 1'b1 && irst === 1'b0) begin
      hs_count++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat got data=%0h row=%0d col=%0d want=no beat", odata, orow, ocol);
      end else begin
        e = exp_q.pop_front();
        last_hs_prev = e.last;
        if ({odata, orow, ocol, olast, ochk} !== e) begin
          n_bad++;
          $display("FAIL beat got data=%0h row=%0d col=%0d last=%0b chk=%0b want data=%0h row=%0d col=%0d last=%0b chk=%0b",
                   odata, orow, ocol, olast, ochk, e.data, e.row, e.col, e.last, e.chk);
        end
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic mat_t make_mat(input int base);
    mat_t m;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        m[i][j] = DW'(base + 4 * i + j);
    return m;
  endfunction

  // Queue one frame; xsum is the checksum word expected when that beat is compiled in.
  task automatic push_frame(input mat_t m, input logic [DW-1:0] xsum);
    beat_t b;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) begin
        b.data = m[i][j];
        b.row  = 2'(i);
        b.col  = 2'(j);
        b.chk  = 1'b0;
`ifdef GEMM_STREAM_CHECKSUM_EN
        b.last = 1'b0;
`else
        b.last = (i == H - 1) && (j == W - 1);
`endif
        exp_q.push_back(b);
      end
`ifdef GEMM_STREAM_CHECKSUM_EN
    b.data = xsum; b.row = 2'd0; b.col = 2'd0; b.last = 1'b1; b.chk = 1'b1;
    exp_q.push_back(b);
`else
    if (xsum == '1) $display("note: checksum word unused in this build");
`endif
  endtask

  task automatic raise_done();
    @(posedge iclk); #1 idone = 1'b1;
  endtask

  task automatic drop_done();
    @(posedge iclk); #1 idone = 1'b0;
  endtask

  // Called right after raise_done: the next posedge is the capture edge.
  task automatic drain(input bit toggle, input int want_cycles, input string name);
    int cyc = 0;
    @(posedge iclk); #1 iready = 1'b1;
    forever begin
      @(negedge iclk);
      cyc++;
      if (ostream_done === 1'b1) break;
      if (cyc > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL %s_timeout got=%0d cycles want=stream_done", name, cyc);
        break;
      end
      @(posedge iclk); #1 if (toggle) iready = ~iready;
    end
    check({name, "_cycles"}, DW'(cyc), DW'(want_cycles));
    check({name, "_queue_empty"}, DW'(exp_q.size()), '0);
    check({name, "_busy_after"}, DW'(obusy), '0);
    check({name, "_valid_after"}, DW'(ovalid), '0);
  endtask

  mat_t m1, m2;
  logic [DW-1:0] x2;
  int   base;
  bit   seen;

  initial begin
    m1 = make_mat(1);
    m2 = make_mat(100);
    x2 = '0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) x2 ^= m2[i][j];
    irst = 1'b1; idone = 1'b0; iready = 1'b0; mat = m1;
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    check("rst_odata", odata, '0);
    check("rst_ovalid_obusy", DW'({ovalid, obusy, olast, ochk}), '0);
    check("rst_flags", DW'({ostream_done, ooverrun, orow, ocol}), '0);
    @(posedge iclk); #1 irst = 1'b0;

    // Zero-wait sink
    push_frame(m1, 64'h10);
    raise_done();
    drain(1'b0, BEATS + 1, "t1");
    check("t1_overrun", DW'(ooverrun), '0);
    drop_done();

    // Alternating ready
    push_frame(m1, 64'h10);
    raise_done();
    drain(1'b1, 2 * BEATS, "t2");
    drop_done();

    // idone held high well past the frame, then an overrun during a second frame
    push_frame(m1, 64'h10);
    raise_done();
    drain(1'b0, BEATS + 1, "t3a");
    repeat (50 - BEATS - 2) @(posedge iclk);
    @(negedge iclk);
    check("t3_no_refire_busy", DW'(obusy), '0);
    check("t3_overrun_clear", DW'(ooverrun), '0);
    drop_done();
    mat = m2;
    push_frame(m2, x2);
    raise_done();
    fork
      drain(1'b0, BEATS + 1, "t3b");
      begin
        repeat (4) @(posedge iclk);
        #1 idone = 1'b0; mat = m1;
        @(posedge iclk); #1 idone = 1'b1;
      end
    join
    check("t3_overrun_set", DW'(ooverrun), 64'd1);
    drop_done();

    // Reset after the fifth handshake with idone still high
    mat = m1;
    push_frame(m1, 64'h10);
    raise_done();
    base = hs_count;
    @(posedge iclk); #1 iready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge iclk);
      if (hs_count >= base + 5) break;
    end
    check("t4_five_beats", DW'(hs_count - base), 64'd5);
    #1 irst = 1'b1; iready = 1'b0;
    @(posedge iclk);
    @(negedge iclk);
    check("t4_valid_after_rst", DW'(ovalid), '0);
    check("t4_outputs_after_rst", DW'({obusy, olast, ochk, ostream_done, ooverrun, orow, ocol}), '0);
    check("t4_odata_after_rst", odata, '0);
    check("t4_beats_left", DW'(exp_q.size()), DW'(BEATS - 5));
    exp_q.delete();
    @(posedge iclk); #1 irst = 1'b0; iready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge iclk);
      seen |= (ovalid === 1'b1);
    end
    check("t4_no_recapture", DW'(seen), '0);
    drop_done();
    push_frame(m1, 64'h10);
    raise_done();
    drain(1'b0, BEATS + 1, "t4b");
    drop_done();

    // Input matrix changes right after capture
    push_frame(m1, 64'h10);
    raise_done();
    fork
      drain(1'b0, BEATS + 1, "t5");
      begin
        @(posedge iclk); #1 mat = '1;
      end
    join
    drop_done();
    mat = m1;

    repeat (3) @(posedge iclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
